mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a shared memory port with a per-access timeout.
// ARBITER_ROUND_ROBIN_EN selects round-robin on simultaneous requests; default is data priority.
module mem_port_arbiter #(
  parameter int unsigned NBits   = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Req0,
  input  logic [NBits-1:0] Addr0,
  input  logic             Req1,
  input  logic [NBits-1:0] Addr1,
  input  logic             WrEn1,
  input  logic             Mem_Ready,
  output logic             Selector,
  output logic [NBits-1:0] Mem_Addr,
  output logic             Mem_Valid,
  output logic             Mem_WrEn,
  output logic             Done0,
  output logic             Done1,
  output logic             Abort
);

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    StIdle,
    StServe0,
    StServe1
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       selector_q, selector_d;
  logic       done0_q, done0_d;
  logic       done1_q, done1_d;
  logic       abort_q, abort_d;
  logic       grant1;

`ifdef ARBITER_ROUND_ROBIN_EN
  logic last_q, last_d;

  // On contention, favour whichever requester was not granted most recently.
  always_comb begin
    grant1 = 1'b0;
    if (Req0 && Req1) begin
      grant1 = ~last_q;
    end else begin
      grant1 = Req1;
    end
  end
`else
  // Data requests win on contention.
  always_comb begin
    grant1 = Req1;
  end
`endif

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    selector_d = selector_q;
    done0_d    = 1'b0;
    done1_d    = 1'b0;
    abort_d    = 1'b0;
`ifdef ARBITER_ROUND_ROBIN_EN
    last_d     = last_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (Req0 || Req1) begin
          state_d    = grant1 ? StServe1 : StServe0;
          selector_d = grant1;
          wait_cnt_d = 8'd0;
`ifdef ARBITER_ROUND_ROBIN_EN
          last_d     = grant1;
`endif
        end
      end
      StServe0, StServe1: begin
        // Ready wins over the timeout when both land in the same cycle.
        if (Mem_Ready) begin
          state_d    = StIdle;
          wait_cnt_d = 8'd0;
          done0_d    = (state_q == StServe0);
          done1_d    = (state_q == StServe1);
        end else if (wait_cnt_q == TimeoutCnt) begin
          state_d    = StIdle;
          wait_cnt_d = 8'd0;
          abort_d    = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d    = StIdle;
        wait_cnt_d = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      wait_cnt_q <= 8'd0;
      selector_q <= 1'b0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      selector_q <= selector_d;
      done0_q    <= done0_d;
      done1_q    <= done1_d;
      abort_q    <= abort_d;
    end
  end

`ifdef ARBITER_ROUND_ROBIN_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  assign Selector  = selector_q;
  assign Mem_Addr  = selector_q ? Addr1 : Addr0;
  assign Mem_Valid = (state_q != StIdle);
  assign Mem_WrEn  = (state_q == StServe1) && WrEn1;
  assign Done0     = done0_q;
  assign Done1     = done1_q;
  assign Abort     = abort_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed table, corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int NB = 32;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          reset, Req0, Req1, WrEn1, Mem_Ready;
  logic [NB-1:0] Addr0, Addr1, Mem_Addr;
  logic          Selector, Mem_Valid, Mem_WrEn, Done0, Done1, Abort;

  int total = 0;
  int bad   = 0;

  mem_port_arbiter #(.NBits(NB), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .Req0      (Req0),
    .Addr0     (Addr0),
    .Req1      (Req1),
    .Addr1     (Addr1),
    .WrEn1     (WrEn1),
    .Mem_Ready (Mem_Ready),
    .Selector  (Selector),
    .Mem_Addr  (Mem_Addr),
    .Mem_Valid (Mem_Valid),
    .Mem_WrEn  (Mem_WrEn),
    .Done0     (Done0),
    .Done1     (Done1),
    .Abort     (Abort)
  );

  always #5 clk = ~clk;

  // Reference model: who holds the port (-1 = nobody) and how long it has waited.
  int m_who, m_wait, m_last;
  bit m_sel, m_d0, m_d1, m_ab;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit rst, input bit r0, input bit r1, input bit wr, input bit rdy);
    @(negedge clk);
    reset = rst; Req0 = r0; Req1 = r1; WrEn1 = wr; Mem_Ready = rdy;
    #1;
  endtask

  task automatic model_advance();
    int pick;
    pick = -1;
    if (!reset) begin
      m_who = -1; m_wait = 0; m_sel = 0; m_d0 = 0; m_d1 = 0; m_ab = 0; m_last = 1;
    end else begin
      m_d0 = 0; m_d1 = 0; m_ab = 0;
      if (m_who < 0) begin
        if (Req0 && Req1) begin
`ifdef ARBITER_ROUND_ROBIN_EN
          pick = (m_last == 1) ? 0 : 1;
`else
          pick = 1;
`endif
        end else if (Req0) pick = 0;
        else if (Req1) pick = 1;
        if (pick >= 0) begin
          m_who = pick; m_sel = (pick == 1); m_last = pick; m_wait = 0;
        end
      end else if (Mem_Ready) begin
        if (m_who == 0) m_d0 = 1; else m_d1 = 1;
        m_who = -1; m_wait = 0;
      end else if (m_wait == TO) begin
        m_ab = 1; m_who = -1; m_wait = 0;
      end else begin
        m_wait++;
      end
    end
  endtask

  function automatic logic [5:0] ctl();
    return {Mem_Valid, Mem_WrEn, Selector, Done0, Done1, Abort};
  endfunction

  typedef struct {
    bit r0, r1, wr, rdy;
    logic [5:0] exp;  // {valid, wren, sel, done0, done1, abort}
  } vec_t;

  vec_t tbl[12];
  int   grants[4];
  int   exp_grants[4];
  int   n, vcnt;
  bit   seen_done, seen_abort, valid_at_abort;
  int   rdy_level;

  initial begin
    tbl[0]  = '{1, 0, 0, 0, 6'b000000};
    tbl[1]  = '{1, 0, 0, 0, 6'b100000};
    tbl[2]  = '{1, 0, 0, 0, 6'b100000};
    tbl[3]  = '{1, 0, 0, 1, 6'b100000};
    tbl[4]  = '{0, 0, 0, 0, 6'b000100};
    tbl[5]  = '{0, 1, 1, 0, 6'b000000};
    tbl[6]  = '{0, 1, 1, 1, 6'b111000};
    tbl[7]  = '{0, 0, 1, 0, 6'b001010};
    tbl[8]  = '{0, 0, 0, 0, 6'b001000};
    tbl[9]  = '{1, 0, 0, 0, 6'b001000};
    tbl[10] = '{1, 0, 0, 1, 6'b100000};
    tbl[11] = '{0, 0, 0, 0, 6'b000100};

    Addr0 = 32'h0040_0000;
    Addr1 = 32'h1001_0004;

    // Directed table: fetch with a 2-cycle ready wait, then a data write.
    drive(0, 0, 0, 0, 0); model_advance();
    drive(1, 0, 0, 0, 0);
    check("reset_ctl", 64'(ctl()), 64'd0);
    check("reset_addr", 64'(Mem_Addr), 64'h0040_0000);
    model_advance();
    for (int i = 0; i < 12; i++) begin
      drive(1, tbl[i].r0, tbl[i].r1, tbl[i].wr, tbl[i].rdy);
      check($sformatf("tbl%0d_ctl", i), 64'(ctl()), 64'(tbl[i].exp));
      check($sformatf("tbl%0d_addr", i), 64'(Mem_Addr),
            tbl[i].exp[3] ? 64'h1001_0004 : 64'h0040_0000);
      model_advance();
    end

    // Contention with immediate ready: grant order after reset.
`ifdef ARBITER_ROUND_ROBIN_EN
    exp_grants = '{0, 1, 0, 1};
`else
    exp_grants = '{1, 1, 1, 1};
`endif
    drive(0, 0, 0, 0, 0); model_advance();
    n = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      drive(1, 1, 1, 0, 1);
      if (Mem_Valid) begin
        grants[n] = int'(Selector);
        n++;
      end
      model_advance();
    end
    check("contention_count", 64'(n), 64'd4);
    for (int i = 0; i < 4; i++) check($sformatf("contention_grant%0d", i),
                                      64'(grants[i]), 64'(exp_grants[i]));

    // Timeout: ready never arrives.
    drive(0, 0, 0, 0, 0); model_advance();
    vcnt = 0; seen_done = 0; seen_abort = 0; valid_at_abort = 1;
    for (int c = 0; c < 100 && !seen_abort; c++) begin
      drive(1, 1, 0, 0, 0);
      if (Done0) seen_done = 1;
      if (Abort) begin
        seen_abort = 1;
        valid_at_abort = Mem_Valid;
      end else if (Mem_Valid) begin
        vcnt++;
      end
      model_advance();
    end
    check("timeout_abort_seen", 64'(seen_abort), 64'd1);
    check("timeout_wait_cycles", 64'(vcnt), 64'(TO + 1));
    check("timeout_no_done", 64'(seen_done), 64'd0);
    check("timeout_idle", 64'(valid_at_abort), 64'd0);

    // Ready arriving in the same cycle the counter reaches the limit completes normally.
    drive(0, 0, 0, 0, 0); model_advance();
    vcnt = 0; seen_done = 0; seen_abort = 0;
    for (int c = 0; c < 100 && !seen_done && !seen_abort; c++) begin
      drive(1, 1, 0, 0, (vcnt == TO));
      if (Done0) seen_done = 1;
      if (Abort) seen_abort = 1;
      if (Mem_Valid) vcnt++;
      model_advance();
    end
    check("edge_done_seen", 64'(seen_done), 64'd1);
    check("edge_no_abort", 64'(seen_abort), 64'd0);

    // Reset in the middle of a data access.
    drive(0, 0, 0, 0, 0); model_advance();
    drive(1, 0, 1, 1, 0); model_advance();
    drive(1, 0, 1, 1, 0);
    check("midreset_serving", 64'(ctl()), 64'b111000);
    model_advance();
    drive(0, 0, 1, 1, 0); model_advance();
    drive(1, 0, 0, 1, 1);
    check("midreset_cleared", 64'(ctl()), 64'd0);
    model_advance();
    drive(1, 0, 0, 1, 1);
    check("midreset_no_pulse", 64'(ctl()), 64'd0);
    model_advance();

    // Randomized traffic against the model.
    rdy_level = 4;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) rdy_level = $urandom_range(0, 7);
      Addr0 = $urandom;
      Addr1 = $urandom;
      drive(($urandom_range(0, 49) != 0), $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 1), ($urandom_range(0, 7) < rdy_level));
      check("random",
            64'({Mem_Valid, Mem_WrEn, Selector, Done0, Done1, Abort, Mem_Addr}),
            64'({(m_who >= 0), (m_who == 1) && WrEn1, m_sel, m_d0, m_d1, m_ab,
                 (m_sel ? Addr1 : Addr0)}));
      model_advance();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
